slider_puzzle_rc: RTL and testbench

//  Parametrised R x C sliding-tile puzzle engine; a formal-verification model and directed-test target.

---
 rtl/slider_puzzle_rc_pkg.sv | 28 ++
 rtl/slider_puzzle_rc_if.sv | 39 +++
 rtl/slider_puzzle_rc_goal_check.sv | 25 ++
 rtl/slider_puzzle_rc.sv | 146 ++++++++++++++
 tb/tb_slider_puzzle_rc.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slider_puzzle_rc_pkg.sv
// Shared types and helpers for the sliding-tile puzzle engine.
package slider_pkg;

  // Direction the blank travels.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  // Engine phases: IDLE accepts a request, EXEC applies it.
  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Row-major cell index.
  function automatic int cell_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

  // Tile expected at a cell in the solved arrangement (blank in the last cell).
  function automatic int goal_tile(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/slider_puzzle_rc_if.sv
// Move handshake, debug load/read and status bundle for slider_puzzle_rc.
interface slider_puzzle_rc_if #(
  parameter int ROWS  = 2,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int TW = $clog2(N);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic             move_valid;
  logic [1:0]       move_dir;
  logic             move_ready;
  logic             move_done;
  logic             move_illegal;
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [TW-1:0]    cfg_data;
  logic [AW-1:0]    rd_addr;
  logic [TW-1:0]    rd_data;
  logic [RW-1:0]    blank_row;
  logic [CW-1:0]    blank_col;
  logic [CNT_W-1:0] move_count;
  logic             solved;

  modport slave (
    input  move_valid, move_dir, cfg_we, cfg_addr, cfg_data, rd_addr,
    output move_ready, move_done, move_illegal, rd_data,
           blank_row, blank_col, move_count, solved
  );

  modport master (
    output move_valid, move_dir, cfg_we, cfg_addr, cfg_data, rd_addr,
    input  move_ready, move_done, move_illegal, rd_data,
           blank_row, blank_col, move_count, solved
  );
endinterface

// File: rtl/slider_puzzle_rc_goal_check.sv
// Combinational comparison of the whole board against the solved arrangement.
module slider_goal_check
  import slider_pkg::*;
#(
  parameter  int ROWS = 2,
  parameter  int COLS = 4,
  localparam int N    = ROWS * COLS,
  localparam int TW   = $clog2(N)
) (
  input  logic [N*TW-1:0] board_flat,
  output logic            match
);

  logic [N-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cell
      assign hit[gi] = (board_flat[gi*TW +: TW] == TW'(goal_tile(gi, N)));
    end
  endgenerate

  assign match = &hit;

endmodule

// File: rtl/slider_puzzle_rc.sv
// R x C sliding-tile puzzle engine: board registers, blank tracking, move FSM,
// saturating move counter, registered solved flag and a debug load/read port.
module slider_puzzle_rc
  import slider_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 4,
  parameter int CNT_W = 16
) (
  input logic          clock,
  input logic          reset_n,
  slider_puzzle_rc_if.slave bus
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int TW = $clog2(N);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW:0] N_L = (AW+1)'(N);

  logic [TW-1:0]    board_q [N];
  logic [TW-1:0]    board_d [N];
  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic [RW-1:0]    brow_q, brow_d;
  logic [CW-1:0]    bcol_q, bcol_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             solved_q, solved_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  logic [N*TW-1:0]  board_flat;
  logic             goal_match;
  logic             legal;
  logic [RW-1:0]    tgt_row;
  logic [CW-1:0]    tgt_col;
  logic [AW-1:0]    blank_idx;
  logic [AW-1:0]    tgt_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flat
      assign board_flat[gi*TW +: TW] = board_q[gi];
    end
  endgenerate

  slider_goal_check #(.ROWS(ROWS), .COLS(COLS)) u_goal (
    .board_flat (board_flat),
    .match      (goal_match)
  );

  assign blank_idx = AW'(cell_idx(int'(brow_q), int'(bcol_q), COLS));
  assign tgt_idx   = AW'(cell_idx(int'(tgt_row), int'(tgt_col), COLS));

  // Next-state: request latch in IDLE, move evaluation in EXEC, debug writes when idle.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    brow_d    = brow_q;
    bcol_d    = bcol_q;
    cnt_d     = cnt_q;
    board_d   = board_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    // Solved reflects the board as it stood one edge earlier.
    solved_d  = goal_match;
    legal     = 1'b0;
    tgt_row   = brow_q;
    tgt_col   = bcol_q;

    case (state_q)
      IDLE: begin
        if (bus.move_valid) begin
          dir_d   = dir_t'(bus.move_dir);
          state_d = EXEC;
        end else if (bus.cfg_we && ({1'b0, bus.cfg_addr} < N_L)) begin
          board_d[bus.cfg_addr] = bus.cfg_data;
          // Writing a zero relocates the blank; no search of the board needed.
          if (bus.cfg_data == '0) begin
            brow_d = RW'(int'(bus.cfg_addr) / COLS);
            bcol_d = CW'(int'(bus.cfg_addr) % COLS);
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
        case (dir_q)
          UP:    if (brow_q != '0)           begin legal = 1'b1; tgt_row = brow_q - RW'(1); end
          DOWN:  if (brow_q < RW'(ROWS - 1)) begin legal = 1'b1; tgt_row = brow_q + RW'(1); end
          LEFT:  if (bcol_q != '0)           begin legal = 1'b1; tgt_col = bcol_q - CW'(1); end
          RIGHT: if (bcol_q < CW'(COLS - 1)) begin legal = 1'b1; tgt_col = bcol_q + CW'(1); end
          default: legal = 1'b0;
        endcase
        if (legal) begin
          board_d[blank_idx] = board_q[tgt_idx];
          board_d[tgt_idx]   = '0;
          brow_d             = tgt_row;
          bcol_d             = tgt_col;
          cnt_d              = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          done_d             = 1'b1;
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; async reset restores the scrambled start board.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        board_q[i] <= TW'(N - 1 - i);
      end
      state_q   <= IDLE;
      dir_q     <= UP;
      brow_q    <= RW'(ROWS - 1);
      bcol_q    <= CW'(COLS - 1);
      cnt_q     <= '0;
      solved_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      board_q   <= board_d;
      state_q   <= state_d;
      dir_q     <= dir_d;
      brow_q    <= brow_d;
      bcol_q    <= bcol_d;
      cnt_q     <= cnt_d;
      solved_q  <= solved_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.move_ready   = (state_q == IDLE);
  assign bus.move_done    = done_q;
  assign bus.move_illegal = illegal_q;
  assign bus.rd_data      = ({1'b0, bus.rd_addr} < N_L) ? board_q[bus.rd_addr] : '0;
  assign bus.blank_row    = brow_q;
  assign bus.blank_col    = bcol_q;
  assign bus.move_count   = cnt_q;
  assign bus.solved       = solved_q;

endmodule

// File: tb/tb_slider_puzzle_rc.sv
// Randomised and directed bench for slider_puzzle_rc (2x4) against a grid-level model.
`timescale 1ns/1ps
module tb_slider_puzzle_rc;
  import slider_pkg::*;

  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  slider_puzzle_rc_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(16)) bus ();
  slider_puzzle_rc_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2))  bus2 ();

  slider_puzzle_rc #(.ROWS(ROWS), .COLS(COLS), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave));
  slider_puzzle_rc #(.ROWS(ROWS), .COLS(COLS), .CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2.slave));

  // The narrow-counter copy sees exactly the same stimulus.
  assign bus2.move_valid = bus.move_valid;
  assign bus2.move_dir   = bus.move_dir;
  assign bus2.cfg_we     = bus.cfg_we;
  assign bus2.cfg_addr   = bus.cfg_addr;
  assign bus2.cfg_data   = bus.cfg_data;
  assign bus2.rd_addr    = bus.rd_addr;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mb[N];
  int mr, mc, mcnt, mbusy, mdir, mdone, mill, msolved;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mb[i] = N - 1 - i;
    mr = ROWS - 1; mc = COLS - 1; mcnt = 0;
    mbusy = 0; mdir = 0; mdone = 0; mill = 0; msolved = 0;
  endfunction

  function automatic bit model_is_goal();
    for (int i = 0; i < N; i++)
      if (mb[i] != ((i == N - 1) ? 0 : i + 1)) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model across one rising edge using the inputs that edge will sample.
  function automatic void model_step();
    bit g;
    int nr, nc;
    g = model_is_goal();
    mdone = 0; mill = 0;
    if (mbusy != 0) begin
      mbusy = 0;
      nr = mr; nc = mc;
      case (mdir)
        0: nr = mr - 1;
        1: nr = mr + 1;
        2: nc = mc - 1;
        default: nc = mc + 1;
      endcase
      if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
        mb[mr*COLS + mc] = mb[nr*COLS + nc];
        mb[nr*COLS + nc] = 0;
        mr = nr; mc = nc;
        if (mcnt < 65535) mcnt++;
        mdone = 1;
      end else begin
        mill = 1;
      end
    end else if (bus.move_valid) begin
      mbusy = 1;
      mdir = int'(bus.move_dir);
    end else if (bus.cfg_we) begin
      mb[bus.cfg_addr] = int'(bus.cfg_data);
      if (bus.cfg_data == 0) begin
        mr = int'(bus.cfg_addr) / COLS;
        mc = int'(bus.cfg_addr) % COLS;
      end
    end
    msolved = g;
  endfunction

  // Compare process: every falling edge the outputs are checked against the model.
  always @(negedge clock) begin
    if (!reset_n) model_reset();
    check("ready",     bus.move_ready,   mbusy == 0);
    check("done",      bus.move_done,    mdone);
    check("illegal",   bus.move_illegal, mill);
    check("blank_row", bus.blank_row,    mr);
    check("blank_col", bus.blank_col,    mc);
    check("count",     bus.move_count,   mcnt);
    check("solved",    bus.solved,       msolved);
    check("count_w2",  bus2.move_count,  (mcnt > 3) ? 3 : mcnt);
    check("done_w2",   bus2.move_done,   mdone);
    if (reset_n) model_step();
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_cell(input int idx, output logic [31:0] val);
    bus.rd_addr = idx[2:0];
    #0.4;
    val = 32'(bus.rd_data);
  endtask

  // Full-board sweep against the model, plus the blank-holds-zero invariant.
  task automatic check_board();
    logic [31:0] v;
    for (int i = 0; i < N; i++) begin
      read_cell(i, v);
      check("board", v, mb[i]);
      if (i == int'(bus.blank_row) * COLS + int'(bus.blank_col))
        check("blank_zero", v, 0);
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = addr[2:0];
    bus.cfg_data = data[2:0];
    tick();
    bus.cfg_we = 1'b0;
  endtask

  // Issue one move; returns just after the edge on which the pulse appears.
  task automatic do_move(input int dir, input bit with_cfg, input int caddr, input int cdata);
    int n;
    n = 0;
    while (!bus.move_ready && n < 8) begin
      tick();
      n++;
    end
    if (!bus.move_ready) check("ready_timeout", 0, 1);
    bus.move_valid = 1'b1;
    bus.move_dir   = dir[1:0];
    if (with_cfg) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = caddr[2:0];
      bus.cfg_data = cdata[2:0];
    end
    tick();
    bus.move_valid = 1'b0;
    bus.cfg_we     = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_board(input int p[N]);
    for (int i = 0; i < N; i++) cfg_write(i, p[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int p[N];
    int j, t, r;

    bus.move_valid = 1'b0;
    bus.move_dir   = 2'd0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.rd_addr    = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // T1: reset board and status.
    for (int i = 0; i < N; i++) begin
      read_cell(i, v);
      check("t1_cell", v, 7 - i);
    end
    check("t1_row", bus.blank_row, 1);
    check("t1_col", bus.blank_col, 3);
    check("t1_count", bus.move_count, 0);
    check("t1_solved", bus.solved, 0);
    check("t1_ready", bus.move_ready, 1);
    tick();

    // T2: blank up from the corner.
    do_move(0, 1'b0, 0, 0);
    check("t2_done", bus.move_done, 1);
    check("t2_ready", bus.move_ready, 1);
    read_cell(3, v); check("t2_cell3", v, 0);
    read_cell(7, v); check("t2_cell7", v, 4);
    check("t2_row", bus.blank_row, 0);
    check("t2_col", bus.blank_col, 3);
    check("t2_count", bus.move_count, 1);
    tick();

    // T3: right and up from (0,3) are both off the board.
    do_move(3, 1'b0, 0, 0);
    check("t3_illegal_r", bus.move_illegal, 1);
    check("t3_done_r", bus.move_done, 0);
    do_move(0, 1'b0, 0, 0);
    check("t3_illegal_u", bus.move_illegal, 1);
    check("t3_count", bus.move_count, 1);
    read_cell(3, v); check("t3_cell3", v, 0);
    tick();
    check_board();
    tick();

    // T4: one move from solved, then away again.
    p = '{1, 2, 3, 4, 5, 6, 0, 7};
    load_board(p);
    check("t4_row", bus.blank_row, 1);
    check("t4_col", bus.blank_col, 2);
    do_move(3, 1'b0, 0, 0);
    check("t4_done", bus.move_done, 1);
    check("t4_solved_early", bus.solved, 0);
    tick();
    check("t4_solved", bus.solved, 1);
    do_move(2, 1'b0, 0, 0);
    tick();
    check("t4_unsolved", bus.solved, 0);

    // T6: reset while a move is executing.
    bus.move_valid = 1'b1;
    bus.move_dir   = 2'd0;
    tick();
    bus.move_valid = 1'b0;
    #1 reset_n = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
    check("t6_done", bus.move_done, 0);
    check("t6_illegal", bus.move_illegal, 0);
    check("t6_ready", bus.move_ready, 1);
    for (int i = 0; i < N; i++) begin
      read_cell(i, v);
      check("t6_cell", v, 7 - i);
    end
    tick();
    // Move and debug write together: the move wins, cell 0 untouched.
    do_move(0, 1'b1, 0, 0);
    check("t6_move_wins", bus.move_done, 1);
    read_cell(0, v); check("t6_cell0", v, 7);
    check("t6_row", bus.blank_row, 0);
    tick();

    // T5: saturation of the 2-bit counter copy.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_move((k % 2 == 0) ? 0 : 1, 1'b0, 0, 0);
      check("t5_count16", bus.move_count, k + 1);
      check("t5_count2", bus2.move_count, (k + 1 > 3) ? 3 : k + 1);
    end
    tick();

    // Randomised phase.
    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        do_move($urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                $urandom_range(0, N - 1), $urandom_range(0, N - 1));
        check_board();
        tick();
      end else if (r < 80) begin
        for (int i = 0; i < N; i++) p[i] = i;
        for (int i = N - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          t = p[i]; p[i] = p[j]; p[j] = t;
        end
        load_board(p);
        check_board();
        tick();
      end else if (r < 85) begin
        for (int i = 0; i < N; i++) p[i] = (i == N - 1) ? 0 : i + 1;
        load_board(p);
        check_board();
        tick();
      end else begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
